// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, reset PC,
// halt opcode, FSM state encoding and the opcode-field helper.
// The halt state is only reachable when FETCH_HALT_EN is defined.
package fetch_pkg;

   localparam int ADDR_W  = 6;
   localparam int INSTR_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC    = '0;
   localparam logic [3:0]        HALT_OPCODE = 4'hF;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter for the fetch sequencer: hold, increment (wrapping at
// 2^ADDR_W) or load a redirect target. Load takes priority over increment.
module fetch_pc_counter
   import fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_pc_i,
   output logic [ADDR_W-1:0] pc_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   // Next-PC select; natural overflow of the adder provides the wrap to 0.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_pc_i;
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   // PC register, cleared to the reset vector asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for a 64 x 16 combinational ROM. Owns the PC,
// captures ROM words into a registered IR and offers them to decode over a
// valid/ready handshake. Redirects flush the IR and restart fetch.
// Optional halt detection is compiled in with FETCH_HALT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; no fetch, IR invalid
// ST_RUN   | fetching one word per cycle whenever the IR can advance
// ST_STALL | IR holds an unaccepted word; wait for ir_ready
// ST_HALT  | halt word captured; no further fetch until redirect
module fetch_sequencer
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] ir_out,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               busy,
   output logic               halted
);

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [INSTR_W-1:0] ir_out_q;
   logic [ADDR_W-1:0]  ir_pc_q;
   logic               ir_valid_q;

   logic [ADDR_W-1:0]  pc;
   logic               advance;
   logic               halt_hit;
   logic               capture;
   logic               pc_load;
   logic               ir_drop;

   assign advance = !ir_valid_q || ir_ready;

`ifdef FETCH_HALT_EN
   assign halt_hit = (opcode_of(imem_data) == HALT_OPCODE);
`else
   assign halt_hit = 1'b0;
`endif

   fetch_pc_counter u_pc (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (capture),
      .load_i    (pc_load),
      .load_pc_i (redirect_pc),
      .pc_o      (pc)
   );

   assign imem_addr = pc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; redirect outranks stall and capture.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) state_d = ST_RUN;
            else if (advance)   state_d = halt_hit ? ST_HALT : ST_RUN;
            else                state_d = ST_STALL;
         end
         ST_STALL: begin
            if (redirect_valid) state_d = ST_RUN;
            else if (ir_ready)  state_d = halt_hit ? ST_HALT : ST_RUN;
         end
`ifdef FETCH_HALT_EN
         ST_HALT: begin
            if (redirect_valid) state_d = ST_RUN;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath strobes decoded from the current state.
   always_comb begin
      capture = 1'b0;
      pc_load = 1'b0;
      ir_drop = 1'b0;
      busy    = 1'b0;
      halted  = 1'b0;
      case (state_q)
         ST_RUN: begin
            busy    = 1'b1;
            pc_load = redirect_valid;
            capture = !redirect_valid && advance;
         end
         ST_STALL: begin
            busy    = 1'b1;
            pc_load = redirect_valid;
            capture = !redirect_valid && ir_ready;
         end
`ifdef FETCH_HALT_EN
         ST_HALT: begin
            halted  = 1'b1;
            pc_load = redirect_valid;
            ir_drop = ir_ready;
         end
`endif
         default: ;
      endcase
   end

   // Instruction register: flush on redirect, load on capture, release the
   // final halt word once decode takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_out_q   <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else if (pc_load) begin
         ir_valid_q <= 1'b0;
      end else if (capture) begin
         ir_out_q   <= imem_data;
         ir_pc_q    <= pc;
         ir_valid_q <= 1'b1;
      end else if (ir_drop) begin
         ir_valid_q <= 1'b0;
      end
   end

   assign ir_out   = ir_out_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a behavioural
// model of the fetch rules (mode / pc / one-slot IR), with a ROM model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] ir_out;
   logic [5:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_valid;
   logic [5:0]  redirect_pc;
   logic        busy;
   logic        halted;

   logic [15:0] rom [64];

   int n_tests = 0;
   int n_fail  = 0;

   // model: mode 0 = idle, 1 = fetching (run or stall), 2 = halted
   int          m_mode;
   int          m_pc;
   bit          m_valid;
   logic [15:0] m_ir;
   int          m_irpc;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   fetch_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .ir_out         (ir_out),
      .ir_pc          (ir_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .halted         (halted)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pc = 0; m_valid = 1'b0; m_ir = '0; m_irpc = 0;
   endtask

   task automatic model_update(input bit s, input bit rdy, input bit rv, input int rpc);
      bit can_take;
      can_take = !m_valid || rdy;
      if (m_mode == 0) begin
         if (s) m_mode = 1;
      end else if (m_mode == 1) begin
         if (rv) begin
            m_pc = rpc; m_valid = 1'b0;
         end else if (can_take) begin
            m_ir    = rom[m_pc];
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_pc    = (m_pc + 1) % 64;
            if (HALT_EN && m_ir[15:12] == 4'hF) m_mode = 2;
         end
      end else begin
         if (rv) begin
            m_mode = 1; m_pc = rpc; m_valid = 1'b0;
         end else if (rdy) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("ir_valid",  32'(ir_valid),  32'(m_valid));
      check("ir_out",    32'(ir_out),    32'(m_ir));
      check("ir_pc",     32'(ir_pc),     32'(m_irpc));
      check("busy",      32'(busy),      32'(m_mode == 1));
      check("halted",    32'(halted),    32'(m_mode == 2));
   endtask

   task automatic step(input bit s, input bit rdy, input bit rv, input int rpc);
      start = s; ir_ready = rdy; redirect_valid = rv; redirect_pc = 6'(rpc);
      model_update(s, rdy, rv, rpc);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      for (int a = 0; a < 64; a++) rom[a] = 16'h1000 + 16'(a);
      rst = 1'b1; start = 1'b0; ir_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      model_reset();
      #3;
      check_all();
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      check_all();

      // start, then streaming with ready held high
      step(1, 1, 0, 0);
      check("first_not_yet_valid", 32'(ir_valid), 32'd0);
      step(0, 1, 0, 0);
      check("first_word", 32'(ir_out), 32'h1000);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      check("word5", 32'(ir_out), 32'h1005);

      // downstream stall for three cycles
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      check("stall_ir_out", 32'(ir_out), 32'h1005);
      check("stall_ir_pc", 32'(ir_pc), 32'd5);
      check("stall_pc", 32'(imem_addr), 32'd6);
      step(0, 1, 0, 0);
      check("after_stall", 32'(ir_out), 32'h1006);

      // wrap 62, 63, 0, 1
      step(0, 1, 1, 62);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
      check("wrap_ir_pc", 32'(ir_pc), 32'd1);

      // redirect during a stall at ir_pc 10
      step(0, 1, 1, 8);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      check("pre_redirect_pc", 32'(ir_pc), 32'd10);
      step(0, 0, 0, 0);
      step(0, 0, 1, 40);
      check("flush_valid", 32'(ir_valid), 32'd0);
      step(0, 1, 0, 0);
      check("redirect_word", 32'(ir_out), 32'h1028);
      check("redirect_ir_pc", 32'(ir_pc), 32'd40);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 14) == 0, int'($urandom_range(0, 63)));
      end

      // asynchronous reset in the middle of a stream at pc 20
      step(0, 1, 1, 17);
      for (int i = 0; i < 10 && m_pc != 20; i++) step(0, 1, 0, 0);
      check("pc_at_20", 32'(imem_addr), 32'd20);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rst_valid", 32'(ir_valid), 32'd0);
      check("rst_ir_out", 32'(ir_out), 32'd0);
      check("rst_pc", 32'(imem_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 1, 1, 33);
      check("idle_after_rst", 32'(busy), 32'd0);
      step(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

`ifdef FETCH_HALT_EN
      rom[7] = 16'hF000;
      step(0, 1, 1, 5);
      for (int i = 0; i < 10 && m_mode != 2; i++) step(0, 1, 0, 0);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_word", 32'(ir_out), 32'hF000);
      check("halt_ir_pc", 32'(ir_pc), 32'd7);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      check("halt_drained", 32'(ir_valid), 32'd0);
      step(1, 1, 0, 0);
      check("halt_start_ignored", 32'(halted), 32'd1);
      step(0, 1, 1, 3);
      check("halt_exit", 32'(halted), 32'd0);
      step(0, 1, 0, 0);
      check("resume_word", 32'(ir_out), 32'h1003);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
